// File: rtl/swt16_pkg.sv
// swt16 hazard control shared types: in-flight slot record,
// source-select encodings and default pipeline depth.
package swt16_pkg;

  localparam int SWT16_DEPTH_DEF = 3;
  localparam int IDX_MAX_W       = 8;

  localparam logic [2:0] SEL_REGFILE = 3'd0;
  localparam logic [2:0] SEL_EX      = 3'd1;
  localparam logic [2:0] SEL_MEM     = 3'd2;

  typedef struct packed {
    logic                 valid;
    logic                 writes;
    logic                 is_load;
    logic [IDX_MAX_W-1:0] dst_idx;
  } slot_t;

endpackage

// File: rtl/swt16_src_match.sv
// Youngest-writer lookup for one source operand.
// Ports: i_used/i_idx source, i_slots (index 0 = EX), o_sel, o_stall_req.
module swt16_src_match
  import swt16_pkg::*;
#(
  parameter int DEPTH      = SWT16_DEPTH_DEF,
  parameter int BYPASS_EX  = 1,
  parameter int BYPASS_MEM = 1
) (
  input  logic                 i_used,
  input  logic [IDX_MAX_W-1:0] i_idx,
  input  slot_t [DEPTH-1:0]    i_slots,
  output logic [2:0]           o_sel,
  output logic                 o_stall_req
);

  logic w_hit;

  // Scan from EX outward; the first hit is the youngest writer.
  always_comb begin
    w_hit       = 1'b0;
    o_sel       = SEL_REGFILE;
    o_stall_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_hit && i_used &&
          i_slots[k].valid && i_slots[k].writes &&
          i_slots[k].dst_idx == i_idx) begin
        w_hit = 1'b1;
        o_sel = 3'(k + 1);
        if (k == 0)
          o_stall_req = i_slots[k].is_load ||
                        (BYPASS_EX == 0);
        else
          // WB slot writes the regfile this cycle:
          // bypassing it is always possible.
          o_stall_req = (BYPASS_MEM == 0) &&
                        (k + 1 < DEPTH);
      end
    end
  end

endmodule

// File: rtl/swt16_hazard_ctrl.sv
// Central stall/bypass control: tracks in-flight writers and selects
// operand sources for DC. Ports: DC record + 3 sources, flush; stall, sels, count.
module swt16_hazard_ctrl
  import swt16_pkg::*;
#(
  parameter int REG_IDX_WIDTH = 4,
  parameter int DEPTH         = SWT16_DEPTH_DEF,
  parameter int BYPASS_EX     = 1,
  parameter int BYPASS_MEM    = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_dc_valid,
  input  logic                     in_dc_writes,
  input  logic                     in_dc_is_load,
  input  logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_src1_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_src2_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_src3_idx,
  input  logic                     in_src1_used,
  input  logic                     in_src2_used,
  input  logic                     in_src3_used,
  input  logic                     in_flush,
  output logic                     out_stall,
  output logic [2:0]               out_src1_sel,
  output logic [2:0]               out_src2_sel,
  output logic [2:0]               out_src3_sel,
  output logic [CNT_WIDTH-1:0]     out_stall_count
);

  slot_t [DEPTH-1:0]    r_slots;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           w_req;
  slot_t                w_new;

  swt16_src_match #(
    .DEPTH(DEPTH), .BYPASS_EX(BYPASS_EX),
    .BYPASS_MEM(BYPASS_MEM)
  ) u_src1 (
    .i_used(in_src1_used),
    .i_idx(IDX_MAX_W'(in_src1_idx)),
    .i_slots(r_slots),
    .o_sel(out_src1_sel),
    .o_stall_req(w_req[0])
  );

  swt16_src_match #(
    .DEPTH(DEPTH), .BYPASS_EX(BYPASS_EX),
    .BYPASS_MEM(BYPASS_MEM)
  ) u_src2 (
    .i_used(in_src2_used),
    .i_idx(IDX_MAX_W'(in_src2_idx)),
    .i_slots(r_slots),
    .o_sel(out_src2_sel),
    .o_stall_req(w_req[1])
  );

  swt16_src_match #(
    .DEPTH(DEPTH), .BYPASS_EX(BYPASS_EX),
    .BYPASS_MEM(BYPASS_MEM)
  ) u_src3 (
    .i_used(in_src3_used),
    .i_idx(IDX_MAX_W'(in_src3_idx)),
    .i_slots(r_slots),
    .o_sel(out_src3_sel),
    .o_stall_req(w_req[2])
  );

  // Flush beats stall: the DC instruction is discarded anyway.
  assign out_stall = in_dc_valid && !in_flush && (|w_req);

  always_comb begin
    w_new         = '0;
    w_new.valid   = in_dc_valid && !out_stall && !in_flush;
    w_new.writes  = in_dc_writes;
    w_new.is_load = in_dc_is_load;
    w_new.dst_idx = IDX_MAX_W'(in_dc_dst_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_slots <= '0;
      r_cnt   <= '0;
    end else begin
      r_slots <= {r_slots[DEPTH-2:0], w_new};
      if (out_stall && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_stall_count = r_cnt;

endmodule
